pipeline_hazard_ctrl: RTL and testbench

//  Control source for the pipeline-register Stall/Flush/NoOp inputs and the ID/EX predict bit.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_branch_predictor.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 88 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: predictor states and PC select codes.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } pred_state_e;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_ID_TGT = 2'b01;
   localparam logic [1:0] PC_SEL_EX_SEQ = 2'b10;
   localparam logic [1:0] PC_SEL_EX_TGT = 2'b11;

endpackage

// File: rtl/pipeline_hazard_ctrl_branch_predictor.sv
// 2-bit saturating branch predictor; trained by branches resolving in EX.
//
// state | meaning
// SNT   | strongly not taken
// WNT   | weakly not taken
// WT    | weakly taken
// ST    | strongly taken
module branch_predictor_2bit
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter logic [1:0] INIT_STATE = 2'b11
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic update_i,
   input  logic taken_i,
   output logic predict_o
);

   pred_state_e state;
   pred_state_e state_next;

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= pred_state_e'(INIT_STATE);
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (update_i) begin
         case (state)
            SNT:     state_next = taken_i ? WNT : SNT;
            WNT:     state_next = taken_i ? WT  : SNT;
            WT:      state_next = taken_i ? ST  : WNT;
            ST:      state_next = taken_i ? ST  : WT;
            default: state_next = pred_state_e'(INIT_STATE);
         endcase
      end
   end

   // prediction comes from the registered state only; same-cycle EX training is not bypassed
   assign predict_o = state[1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch predict/redirect and mispredict flush control, plus branch statistics.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter logic [1:0] INIT_STATE = 2'b11,
   parameter int         CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ID_rs1_addr_i,
   input  logic [4:0]       ID_rs2_addr_i,
   input  logic             ID_Branch_i,
   input  logic             EX_MemRead_i,
   input  logic [4:0]       EX_rd_addr_i,
   input  logic             EX_Branch_i,
   input  logic             EX_predict_i,
   input  logic             EX_taken_i,
   output logic             PCWrite_o,
   output logic             Stall_o,
   output logic             NoOp_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Flush_o,
   output logic             predict_o,
   output logic [1:0]       PC_sel_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   logic mispredict;
   logic load_use;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   assign mispredict = EX_Branch_i & (EX_predict_i != EX_taken_i);
   assign load_use   = EX_MemRead_i & (EX_rd_addr_i != 5'd0) &
                       ((EX_rd_addr_i == ID_rs1_addr_i) | (EX_rd_addr_i == ID_rs2_addr_i));

   branch_predictor_2bit #(
      .INIT_STATE (INIT_STATE)
   ) u_predictor (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .update_i  (EX_Branch_i),
      .taken_i   (EX_taken_i),
      .predict_o (predict_o)
   );

   always_comb begin
      PCWrite_o    = 1'b1;
      Stall_o      = 1'b0;
      NoOp_o       = 1'b0;
      IFID_Flush_o = 1'b0;
      IDEX_Flush_o = 1'b0;
      PC_sel_o     = PC_SEL_SEQ;
      if (!rst_i) begin
         // keep the pipeline drained and the PC frozen while in reset
         PCWrite_o    = 1'b0;
         NoOp_o       = 1'b1;
         IFID_Flush_o = 1'b1;
         IDEX_Flush_o = 1'b1;
      end else if (mispredict) begin
         IFID_Flush_o = 1'b1;
         IDEX_Flush_o = 1'b1;
         PC_sel_o     = EX_taken_i ? PC_SEL_EX_TGT : PC_SEL_EX_SEQ;
      end else if (load_use) begin
         PCWrite_o = 1'b0;
         Stall_o   = 1'b1;
         NoOp_o    = 1'b1;
      end else if (ID_Branch_i && predict_o) begin
         IFID_Flush_o = 1'b1;
         PC_sel_o     = PC_SEL_ID_TGT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (EX_Branch_i) begin
         if (branch_cnt != '1)                  branch_cnt  <= branch_cnt + CNT_W'(1);
         if (mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end

   assign branch_cnt_o  = branch_cnt;
   assign mispred_cnt_o = mispred_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       idb, mr, eb, ep, et;

   logic        pcw, stall, noop, f_ifid, f_idex, pred;
   logic [1:0]  sel;
   logic [31:0] bc, mc;
   logic        pcw_s, stall_s, noop_s, f_ifid_s, f_idex_s, pred_s;
   logic [1:0]  sel_s;
   logic [3:0]  bc_s, mc_s;

   int errors = 0;
   int checks = 0;

   // behavioural model: predictor strength 0..3 and unbounded counts clipped at each width
   int     m_st  = 3;
   longint m_bc  = 0, m_mc  = 0;
   int     m_bc4 = 0, m_mc4 = 0;

   pipeline_hazard_ctrl dut (
      .clk_i(clk), .rst_i(rst), .ID_rs1_addr_i(rs1), .ID_rs2_addr_i(rs2), .ID_Branch_i(idb),
      .EX_MemRead_i(mr), .EX_rd_addr_i(rd), .EX_Branch_i(eb), .EX_predict_i(ep), .EX_taken_i(et),
      .PCWrite_o(pcw), .Stall_o(stall), .NoOp_o(noop), .IFID_Flush_o(f_ifid), .IDEX_Flush_o(f_idex),
      .predict_o(pred), .PC_sel_o(sel), .branch_cnt_o(bc), .mispred_cnt_o(mc)
   );

   pipeline_hazard_ctrl #(.CNT_W(4)) dut_small (
      .clk_i(clk), .rst_i(rst), .ID_rs1_addr_i(rs1), .ID_rs2_addr_i(rs2), .ID_Branch_i(idb),
      .EX_MemRead_i(mr), .EX_rd_addr_i(rd), .EX_Branch_i(eb), .EX_predict_i(ep), .EX_taken_i(et),
      .PCWrite_o(pcw_s), .Stall_o(stall_s), .NoOp_o(noop_s), .IFID_Flush_o(f_ifid_s),
      .IDEX_Flush_o(f_idex_s), .predict_o(pred_s), .PC_sel_o(sel_s), .branch_cnt_o(bc_s),
      .mispred_cnt_o(mc_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic e_pred, mis, lu;
      logic e_pcw, e_stall, e_noop, e_f1, e_f2;
      logic [1:0] e_sel;
      e_pred = (m_st >= 2);
      mis    = eb && (ep != et);
      lu     = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
      e_pcw = 1; e_stall = 0; e_noop = 0; e_f1 = 0; e_f2 = 0; e_sel = 2'd0;
      if (!rst) begin
         e_pcw = 0; e_noop = 1; e_f1 = 1; e_f2 = 1;
      end else if (mis) begin
         e_f1 = 1; e_f2 = 1; e_sel = et ? 2'd3 : 2'd2;
      end else if (lu) begin
         e_pcw = 0; e_stall = 1; e_noop = 1;
      end else if (idb && e_pred) begin
         e_f1 = 1; e_sel = 2'd1;
      end
      check({tag, "/pcw"},     pcw,     e_pcw);
      check({tag, "/stall"},   stall,   e_stall);
      check({tag, "/noop"},    noop,    e_noop);
      check({tag, "/ifid_fl"}, f_ifid,  e_f1);
      check({tag, "/idex_fl"}, f_idex,  e_f2);
      check({tag, "/pc_sel"},  sel,     e_sel);
      check({tag, "/predict"}, pred,    e_pred);
      check({tag, "/br_cnt"},  bc,      m_bc);
      check({tag, "/mp_cnt"},  mc,      m_mc);
      check({tag, "/s_outs"},  {pcw_s, stall_s, noop_s, f_ifid_s, f_idex_s, sel_s},
                               {e_pcw, e_stall, e_noop, e_f1, e_f2, e_sel});
      check({tag, "/s_pred"},  pred_s,  e_pred);
      check({tag, "/s_br"},    bc_s,    m_bc4);
      check({tag, "/s_mp"},    mc_s,    m_mc4);
   endtask

   task automatic model_clock();
      if (!rst) begin
         m_st = 3; m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      end else if (eb) begin
         if (m_bc  < 64'hFFFF_FFFF) m_bc++;
         if (m_bc4 < 15)            m_bc4++;
         if (ep != et) begin
            if (m_mc  < 64'hFFFF_FFFF) m_mc++;
            if (m_mc4 < 15)            m_mc4++;
         end
         m_st = et ? ((m_st == 3) ? 3 : m_st + 1) : ((m_st == 0) ? 0 : m_st - 1);
      end
   endtask

   // inputs are already set (just after a falling edge); check, clock, advance model
   task automatic cycle(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic set_in(input logic r, input logic [4:0] a1, input logic [4:0] a2, input logic ib,
                         input logic m, input logic [4:0] d, input logic b, input logic p,
                         input logic t);
      rst = r; rs1 = a1; rs2 = a2; idb = ib; mr = m; rd = d; eb = b; ep = p; et = t;
   endtask

   int walk_exp[4] = '{1, 0, 0, 0};

   initial begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cycle("rst0");
      cycle("rst1");

      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("rel_pred", pred, 1);
      check("rel_cnt", bc, 0);
      check("rel_pcw", pcw, 1);
      check("rel_flush", {f_ifid, f_idex}, 2'b00);
      cycle("idle");

      set_in(1, 3, 5, 0, 1, 5, 0, 0, 0);
      #1;
      check("lu_stall", {pcw, stall, noop}, 3'b011);
      cycle("lu");
      set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
      #1;
      check("lu_rd0", stall, 0);
      cycle("lu_rd0");

      set_in(1, 7, 8, 1, 0, 0, 0, 0, 0);
      #1;
      check("idpred_sel", {f_ifid, sel}, 3'b101);
      cycle("idpred");
      set_in(1, 7, 8, 1, 1, 8, 0, 0, 0);
      #1;
      check("idpred_lu", {stall, sel}, 3'b100);
      cycle("idpred_lu");

      set_in(1, 5, 6, 1, 1, 5, 1, 1, 0);
      #1;
      check("mp_out", {f_ifid, f_idex, sel, stall}, 5'b11100);
      cycle("mp");
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("mp_after", {pred, mc, bc}, {1'b1, 32'd1, 32'd1});
      cycle("mp_after");

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("rst_walk");
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
         cycle("walk_nt");
         #1;
         check("walk_pred", pred, walk_exp[i]);
      end
      for (int i = 0; i < 2; i++) begin
         set_in(1, 0, 0, 0, 0, 0, 1, 0, 1);
         cycle("walk_t");
      end
      #1;
      check("walk_back", pred, 1);

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("rst_sat");
      for (int i = 0; i < 17; i++) begin
         set_in(1, 0, 0, 0, 0, 0, 1, pred, 1'($urandom_range(0, 1)));
         cycle("sat");
      end
      #1;
      check("sat_small", bc_s, 4'hF);
      check("sat_wide", bc, 32'd17);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("rst_mid");
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("rst_mid_cnt", {bc_s, mc_s, bc}, 40'd0);
      check("rst_mid_pred", pred, 1);
      cycle("post_rst");

      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 39) != 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
